// File: rtl/fence_flush_sequencer.sv
// Sequences the multi-cycle side effects of fence.i / fence / sfence.vma / AMO-commit flushes:
// store-buffer drain, D$ flush, I$ invalidate or TLB flush, then pipeline flush and redirect.
module fence_flush_sequencer #(
    parameter int unsigned VLEN          = 64,
    parameter int unsigned DRAIN_TIMEOUT = 1024
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            fence_i_i,
    input  logic            fence_i,
    input  logic            sfence_vma_i,
    input  logic            flush_commit_i,
    input  logic [VLEN-1:0] pc_i,
    input  logic            is_compressed_i,
    input  logic            no_st_pending_i,
    input  logic            flush_dcache_ack_i,
    output logic            flush_dcache_o,
    output logic            flush_icache_o,
    output logic            flush_tlb_o,
    output logic            flush_pipeline_o,
    output logic            set_pc_o,
    output logic [VLEN-1:0] resume_pc_o,
    output logic            busy_o,
    output logic            timeout_o
);

    localparam int unsigned CNT_W   = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
    localparam int unsigned TO_LAST = (DRAIN_TIMEOUT == 0) ? 0 : DRAIN_TIMEOUT - 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_DCACHE,
        S_ICACHE,
        S_TLB,
        S_FLUSH
    } state_e;

    typedef enum logic [1:0] {
        K_FENCE_I,
        K_FENCE,
        K_SFENCE,
        K_AMO
    } kind_e;

    state_e           state_q, state_d;
    kind_e            kind_q, kind_d;
    logic [VLEN-1:0]  pend_pc_q, pend_pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
    logic             timeout_hit_c;

    logic             flush_dcache_q, flush_dcache_d;
    logic             flush_icache_q, flush_icache_d;
    logic             flush_tlb_q, flush_tlb_d;
    logic             flush_pipeline_q, flush_pipeline_d;
    logic [VLEN-1:0]  resume_pc_q, resume_pc_d;
    logic             busy_q, busy_d;

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Sequence context: request kind, redirect target, drain counter, sticky timeout
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            kind_q    <= K_AMO;
            pend_pc_q <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            kind_q    <= kind_d;
            pend_pc_q <= pend_pc_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_hit_c = (DRAIN_TIMEOUT != 0) && (cnt_q == CNT_W'(TO_LAST));

    // Next-state and context update
    always_comb begin
        state_d   = state_q;
        kind_d    = kind_q;
        pend_pc_d = pend_pc_q;
        cnt_d     = '0;
        timeout_d = timeout_q;
        unique case (state_q)
            S_IDLE: begin
                if (fence_i_i || fence_i || sfence_vma_i || flush_commit_i) begin
                    pend_pc_d = pc_i + (is_compressed_i ? VLEN'(2) : VLEN'(4));
                end
                if (fence_i_i) begin
                    state_d = S_DRAIN;
                    kind_d  = K_FENCE_I;
                end else if (fence_i) begin
                    state_d = S_DRAIN;
                    kind_d  = K_FENCE;
                end else if (sfence_vma_i) begin
                    state_d = S_DRAIN;
                    kind_d  = K_SFENCE;
                end else if (flush_commit_i) begin
                    state_d = S_FLUSH;
                    kind_d  = K_AMO;
                end
            end
            S_DRAIN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (no_st_pending_i || timeout_hit_c) begin
                    state_d = (kind_q == K_SFENCE) ? S_TLB : S_DCACHE;
                end
                // Timeout only flags a drain that genuinely never completed
                if (!no_st_pending_i && timeout_hit_c) begin
                    timeout_d = 1'b1;
                end
            end
            S_DCACHE: begin
                if (flush_dcache_ack_i) begin
                    state_d = (kind_q == K_FENCE_I) ? S_ICACHE : S_FLUSH;
                end
            end
            S_ICACHE: state_d = S_FLUSH;
            S_TLB:    state_d = S_FLUSH;
            S_FLUSH:  state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Moore outputs decoded from the upcoming state so they register alongside it
    always_comb begin
        flush_dcache_d   = (state_d == S_DCACHE);
        flush_icache_d   = (state_d == S_ICACHE);
        flush_tlb_d      = (state_d == S_TLB);
        flush_pipeline_d = (state_d == S_FLUSH);
        busy_d           = (state_d != S_IDLE);
        resume_pc_d      = resume_pc_q;
        if (state_d == S_FLUSH) begin
            resume_pc_d = pend_pc_d;
        end
    end

    // Output registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            flush_dcache_q   <= 1'b0;
            flush_icache_q   <= 1'b0;
            flush_tlb_q      <= 1'b0;
            flush_pipeline_q <= 1'b0;
            resume_pc_q      <= '0;
            busy_q           <= 1'b0;
        end else begin
            flush_dcache_q   <= flush_dcache_d;
            flush_icache_q   <= flush_icache_d;
            flush_tlb_q      <= flush_tlb_d;
            flush_pipeline_q <= flush_pipeline_d;
            resume_pc_q      <= resume_pc_d;
            busy_q           <= busy_d;
        end
    end

    assign flush_dcache_o   = flush_dcache_q;
    assign flush_icache_o   = flush_icache_q;
    assign flush_tlb_o      = flush_tlb_q;
    assign flush_pipeline_o = flush_pipeline_q;
    assign set_pc_o         = flush_pipeline_q;
    assign resume_pc_o      = resume_pc_q;
    assign busy_o           = busy_q;
    assign timeout_o        = timeout_q;

endmodule

// File: tb/tb_fence_flush_sequencer.sv
// Bench for fence_flush_sequencer: directed scenarios with literal expectations plus randomized
// traffic compared every cycle against a plan-queue model of the flush sequences.
module tb_fence_flush_sequencer;

    localparam int unsigned VLEN = 64;
    localparam int unsigned TO   = 8;

    localparam int P_DRAIN  = 1;
    localparam int P_DCACHE = 2;
    localparam int P_ICACHE = 3;
    localparam int P_TLB    = 4;
    localparam int P_FLUSH  = 5;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            fence_ii, fence_p, sfence, flush_commit;
    logic [VLEN-1:0] pc;
    logic            comp, nsp, ack;
    logic            dcache_o, icache_o, tlb_o, pipe_o, setpc_o, busy_o, to_o;
    logic [VLEN-1:0] resume_o;

    int checks = 0;
    int errors = 0;

    fence_flush_sequencer #(.VLEN(VLEN), .DRAIN_TIMEOUT(TO)) dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .fence_i_i          (fence_ii),
        .fence_i            (fence_p),
        .sfence_vma_i       (sfence),
        .flush_commit_i     (flush_commit),
        .pc_i               (pc),
        .is_compressed_i    (comp),
        .no_st_pending_i    (nsp),
        .flush_dcache_ack_i (ack),
        .flush_dcache_o     (dcache_o),
        .flush_icache_o     (icache_o),
        .flush_tlb_o        (tlb_o),
        .flush_pipeline_o   (pipe_o),
        .set_pc_o           (setpc_o),
        .resume_pc_o        (resume_o),
        .busy_o             (busy_o),
        .timeout_o          (to_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an accepted request becomes a plan of steps; the head step defines the outputs.
    int          plan[$];
    int          m_cnt;
    logic        m_to;
    logic [63:0] m_pend, m_res;
    int          m_head;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            plan.delete();
            m_cnt  = 0;
            m_to   = 1'b0;
            m_pend = '0;
            m_res  = '0;
        end else begin
            if (plan.size() == 0) begin
                if (fence_ii) begin
                    plan.push_back(P_DRAIN); plan.push_back(P_DCACHE);
                    plan.push_back(P_ICACHE); plan.push_back(P_FLUSH);
                end else if (fence_p) begin
                    plan.push_back(P_DRAIN); plan.push_back(P_DCACHE); plan.push_back(P_FLUSH);
                end else if (sfence) begin
                    plan.push_back(P_DRAIN); plan.push_back(P_TLB); plan.push_back(P_FLUSH);
                end else if (flush_commit) begin
                    plan.push_back(P_FLUSH);
                end
                if (plan.size() != 0) begin
                    m_pend = pc + (comp ? 64'd2 : 64'd4);
                    m_cnt  = 0;
                end
            end else begin
                case (plan[0])
                    P_DRAIN: begin
                        m_cnt++;
                        if (nsp) void'(plan.pop_front());
                        else if (m_cnt == TO) begin
                            m_to = 1'b1;
                            void'(plan.pop_front());
                        end
                    end
                    P_DCACHE: if (ack) void'(plan.pop_front());
                    default:  void'(plan.pop_front());
                endcase
            end
            if (plan.size() != 0 && plan[0] == P_FLUSH) m_res = m_pend;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        m_head = (plan.size() != 0) ? plan[0] : 0;
        chk("busy",      busy_o,   m_head != 0);
        chk("dcache",    dcache_o, m_head == P_DCACHE);
        chk("icache",    icache_o, m_head == P_ICACHE);
        chk("tlb",       tlb_o,    m_head == P_TLB);
        chk("pipeline",  pipe_o,   m_head == P_FLUSH);
        chk("set_pc",    setpc_o,  m_head == P_FLUSH);
        chk("resume_pc", resume_o, m_res);
        chk("timeout",   to_o,     m_to);
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic clr();
        fence_ii = 0; fence_p = 0; sfence = 0; flush_commit = 0; ack = 0;
    endtask

    initial begin
        rst_n = 0; clr(); pc = '0; comp = 0; nsp = 1;
        cyc();
        chk("rst_busy", busy_o, 0);
        chk("rst_resume", resume_o, 0);
        chk("rst_timeout", to_o, 0);
        cyc(); rst_n = 1;
        cyc();

        // 1: AMO flush
        flush_commit = 1; pc = 64'h8000_0000; comp = 0;
        cyc(); clr();
        chk("t1_pipe", pipe_o, 1);
        chk("t1_setpc", setpc_o, 1);
        chk("t1_resume", resume_o, 64'h8000_0004);
        cyc();
        chk("t1_busy_c2", busy_o, 0);
        cyc();

        // 2: fence.i with delayed drain and ack at c8
        fence_ii = 1; pc = 64'h100; comp = 1; nsp = 0;
        for (int c = 1; c <= 11; c++) begin
            cyc();
            chk("t2_dcache", dcache_o, (c >= 6 && c <= 8));
            chk("t2_icache", icache_o, c == 9);
            chk("t2_pipe", pipe_o, c == 10);
            if (c == 10) chk("t2_resume", resume_o, 64'h102);
            if (c == 1) clr();
            if (c == 5) nsp = 1;
            ack = (c == 8);
        end

        // 3: sfence.vma with empty store buffer
        sfence = 1; pc = 64'h4000;
        for (int c = 1; c <= 5; c++) begin
            cyc(); clr();
            chk("t3_busy", busy_o, c <= 3);
            chk("t3_tlb", tlb_o, c == 2);
            chk("t3_pipe", pipe_o, c == 3);
            chk("t3_dcache", dcache_o, 0);
        end

        // 4: simultaneous fence.i + sfence, then fence while busy
        fence_ii = 1; sfence = 1; pc = 64'h200; comp = 0;
        for (int c = 1; c <= 8; c++) begin
            cyc(); clr();
            chk("t4_tlb", tlb_o, 0);
            chk("t4_icache", icache_o, c == 4);
            chk("t4_pipe", pipe_o, c == 5);
            chk("t4_busy", busy_o, c <= 5);
            if (c == 1) fence_p = 1;
            if (c == 3) ack = 1;
        end
        chk("t4_resume", resume_o, 64'h204);

        // 7: address wrap
        flush_commit = 1; pc = 64'hFFFF_FFFF_FFFF_FFFC; comp = 0;
        cyc(); clr();
        chk("t7_resume", resume_o, 64'h0);
        cyc(); cyc();

        // 5: drain timeout
        chk("t5_to_before", to_o, 0);
        fence_p = 1; pc = 64'h300; nsp = 0;
        for (int c = 1; c <= 11; c++) begin
            cyc();
            if (c == 1) clr();
            chk("t5_timeout", to_o, c >= 9);
            chk("t5_dcache", dcache_o, c == 9);
            chk("t5_pipe", pipe_o, c == 10);
            ack = (c == 9);
        end
        nsp = 1; flush_commit = 1; pc = 64'h500;
        cyc(); clr(); cyc(); cyc();
        chk("t5_to_sticky", to_o, 1);

        // 6: reset during DCACHE
        fence_p = 1; pc = 64'h600;
        cyc(); clr();
        cyc();
        chk("t6_dcache_pre", dcache_o, 1);
        #2 rst_n = 0;
        #1;
        chk("t6_rst_dcache", dcache_o, 0);
        chk("t6_rst_busy", busy_o, 0);
        chk("t6_rst_to", to_o, 0);
        chk("t6_rst_resume", resume_o, 0);
        cyc(); rst_n = 1; ack = 1;
        cyc(); ack = 0;
        chk("t6_ack_busy", busy_o, 0);
        chk("t6_ack_dcache", dcache_o, 0);
        flush_commit = 1; pc = 64'h2000; comp = 1;
        cyc(); clr();
        chk("t6_next_pipe", pipe_o, 1);
        chk("t6_next_resume", resume_o, 64'h2002);
        cyc();

        // Randomized traffic
        begin
            int stuck = 0;
            for (int i = 0; i < 4000; i++) begin
                cyc();
                if (i % 700 == 350) begin
                    #3 rst_n = 0;
                    cyc();
                    rst_n = 1;
                end
                fence_ii     = ($urandom_range(0, 9) == 0);
                fence_p      = ($urandom_range(0, 9) == 0);
                sfence       = ($urandom_range(0, 9) == 0);
                flush_commit = ($urandom_range(0, 9) == 0);
                pc           = {$urandom, $urandom};
                if ($urandom_range(0, 15) == 0) pc[63:3] = '1;
                comp         = $urandom_range(0, 1) == 1;
                if (stuck == 0 && $urandom_range(0, 199) == 0) stuck = 14;
                if (stuck > 0) begin
                    stuck--;
                    nsp = 0;
                end else begin
                    nsp = ($urandom_range(0, 2) != 0);
                end
                ack = ($urandom_range(0, 3) == 0);
            end
        end
        cyc(); clr();
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
